prop_chk_mon: RTL and testbench
===============================

# prop_chk_mon

Parametrised multi-channel property monitor: synthesizable RTL that evaluates a simple temporal property per channel on every enabled clock edge and accumulates pass/fail statistics. It generalises a single-signal "a must be high at posedge clk" assertion to NCH channels, three runtime-selectable property modes, an implication delay and first-failure capture. It sits beside the DUT in simulation benches and in debug builds as a hardware checker whose counters are read out by the bench or a debug bus.

## Interface
- NCH, 4, number of channels checked in parallel (1..32)
- CNT_W, 16, width of every counter and of the cycle stamp
- DLY, 2, implication delay in cycles for mode IMPL (1..15)
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- clr  in  1  synchronous clear of counters and failure capture
- en  in  1  evaluation enable
- mode  in  2  0=HIGH, 1=LOW, 2=IMPL, 3=OFF
- ante  in  NCH  per-channel antecedent (IMPL only)
- cons  in  NCH  per-channel checked signal
- pass_pulse  out  NCH  one-cycle pass strobe per channel
- fail_pulse  out  NCH  one-cycle fail strobe per channel
- pass_cnt  out  NCH*CNT_W  pass counters, channel i at [i*CNT_W +: CNT_W]
- fail_cnt  out  NCH*CNT_W  fail counters, same packing
- vac_cnt  out  NCH*CNT_W  vacuous-pass counters, same packing
- cyc_cnt  out  CNT_W  enabled-cycle counter
- first_fail_vld  out  1  sticky: a failure has occurred
- first_fail_ch  out  5  channel index of first failure
- first_fail_cyc  out  CNT_W  cyc_cnt value at first failure

## Operation
- Evaluation cycle = posedge with en=1, rst=0, clr=0.
- HIGH: channel passes if cons[i]=1, else fails. LOW: passes if cons[i]=0. ante ignored.
- IMPL: per-channel DLY-deep attempt shift register. Each evaluation cycle shifts in ante[i]; slot leaving the register matures. Matured 1: pass if cons[i]=1 in that cycle, else fail. Matured 0: vacuous. Overlapping attempts independent.
- OFF: no evaluation; counters, cyc_cnt, shift registers hold.
- en=0: everything holds (shift registers frozen, no pulses).
- Mode change (registered mode differs from input mode): shift registers cleared that cycle; that cycle is not evaluated; new mode active next cycle.
- Counters: +1 per pass/fail/vacuous event, saturate at 2^CNT_W-1. cyc_cnt increments per evaluation cycle, saturates.
- First failure: on first cycle with any fail, capture lowest failing channel index and current cyc_cnt (pre-increment), set first_fail_vld; later failures ignored until clr/rst.
- clr: same effect as rst on all state except registered mode; clr in an evaluation cycle wins, evaluation discarded.

## Timing
- rst: all outputs 0, counters 0, shift registers 0, registered mode = OFF.
- HIGH/LOW: cons sampled at edge t, pulse and counter update visible after edge t+1 (latency 1).
- IMPL: ante sampled at evaluation cycle t, cons at evaluation cycle t+DLY, pulse after the following edge; first DLY cycles after reset/clear/mode change produce vacuous events only.
- Pulses are exactly one cycle; pass and fail never both high on one channel.
- Saturated counter stays at max; no wrap.

## Configuration
- PCM_VACUOUS_CNT_EN defined: vac_cnt counts matured-0 slots in IMPL.
- Not defined: vac_cnt tied to 0, vacuous counter logic removed; pass/fail behaviour unchanged.

## Test plan
- Reset then mode=HIGH, cons=4'b1111 for 10 cycles -> each pass_cnt=10, fail_cnt=0, first_fail_vld=0.
- HIGH, cons[2]=0 only at the 4th evaluation cycle -> fail_pulse[2] one cycle, fail_cnt ch2=1, first_fail_ch=2, first_fail_cyc=3.
- IMPL DLY=2, ante[0]=1 at cycle 5, cons[0]=1 at 7 -> pass_pulse[0] after edge 8; cons[0]=0 at 7 instead -> fail; with macro, vac_cnt ch0 counts all other matured cycles.
- CNT_W=4, HIGH, 20 passing cycles -> pass_cnt saturates at 15.
- Failures on ch1 and ch3 in same cycle -> first_fail_ch=1; later ch0 failure leaves capture unchanged; clr -> all counters 0, first_fail_vld=0.
- IMPL with attempt pending, switch to LOW -> no IMPL result, shift register flushed, LOW results begin one cycle after switch; en=0 for 5 cycles -> counters and cyc_cnt hold.

Source files
------------

// File: rtl/prop_chk_mon.sv
// prop_chk_mon: multi-channel temporal property monitor.
// Each channel is checked against a runtime-selected mode (HIGH, LOW, IMPL, OFF)
// on every enabled clock edge. Pass, fail and vacuous events are counted, and
// the first failure is captured.
// The results of an evaluation edge are held in a stage register, so pulses
// and counters change one edge after the inputs are sampled.
// Optional feature: define PCM_VACUOUS_CNT_EN to count vacuous IMPL results.
module prop_chk_mon #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16,
  parameter int DLY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [NCH-1:0]       ante,
  input  logic [NCH-1:0]       cons,
  output logic [NCH-1:0]       pass_pulse,
  output logic [NCH-1:0]       fail_pulse,
  output logic [NCH*CNT_W-1:0] pass_cnt,
  output logic [NCH*CNT_W-1:0] fail_cnt,
  output logic [NCH*CNT_W-1:0] vac_cnt,
  output logic [CNT_W-1:0]     cyc_cnt,
  output logic                 first_fail_vld,
  output logic [4:0]           first_fail_ch,
  output logic [CNT_W-1:0]     first_fail_cyc
);

  localparam logic [1:0] MODE_HIGH = 2'd0;
  localparam logic [1:0] MODE_LOW  = 2'd1;
  localparam logic [1:0] MODE_IMPL = 2'd2;
  localparam logic [1:0] MODE_OFF  = 2'd3;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]       mode_q, mode_d;
  logic [NCH-1:0]   sr_q [DLY];
  logic [NCH-1:0]   sr_d [DLY];
  logic [NCH-1:0]   stg_pass_q, stg_pass_d, stg_fail_q, stg_fail_d;
  logic             stg_eval_q, stg_eval_d;
  logic [NCH-1:0]   pp_q, pp_d, fp_q, fp_d;
  logic [CNT_W-1:0] pass_q [NCH];
  logic [CNT_W-1:0] pass_d [NCH];
  logic [CNT_W-1:0] fail_q [NCH];
  logic [CNT_W-1:0] fail_d [NCH];
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             ffv_q, ffv_d;
  logic [4:0]       ffch_q, ffch_d;
  logic [CNT_W-1:0] ffcyc_q, ffcyc_d;
  logic [4:0]       low_idx;
  logic             found;
  logic             mode_chg;
  logic             eval;
  logic [NCH-1:0]   matured;

  // A mode change only takes effect on an enabled edge, and that edge is not evaluated.
  assign mode_chg = en && (mode != mode_q);
  assign eval     = en && !mode_chg && (mode_q != MODE_OFF);
  assign matured  = sr_q[DLY-1];

  // Next-state logic: commit the staged results, then evaluate the current edge.
  always_comb begin
    mode_d     = mode_q;
    sr_d       = sr_q;
    stg_pass_d = '0;
    stg_fail_d = '0;
    stg_eval_d = 1'b0;
    pp_d       = stg_pass_q;
    fp_d       = stg_fail_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    cyc_d      = cyc_q;
    ffv_d      = ffv_q;
    ffch_d     = ffch_q;
    ffcyc_d    = ffcyc_q;
    low_idx    = '0;
    found      = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (stg_pass_q[k]) pass_d[k] = sat_inc(pass_q[k]);
      if (stg_fail_q[k]) fail_d[k] = sat_inc(fail_q[k]);
      if (stg_fail_q[k] && !found) begin
        low_idx = k[4:0];
        found   = 1'b1;
      end
    end
    if (stg_eval_q) cyc_d = sat_inc(cyc_q);
    // cyc_q still holds the stamp of the failing edge because it increments on this same edge.
    if (found && !ffv_q) begin
      ffv_d   = 1'b1;
      ffch_d  = low_idx;
      ffcyc_d = cyc_q;
    end
    if (mode_chg) begin
      mode_d = mode;
      sr_d   = '{default: '0};
    end else if (eval) begin
      stg_eval_d = 1'b1;
      case (mode_q)
        MODE_HIGH: begin
          stg_pass_d = cons;
          stg_fail_d = ~cons;
        end
        MODE_LOW: begin
          stg_pass_d = ~cons;
          stg_fail_d = cons;
        end
        MODE_IMPL: begin
          stg_pass_d = matured & cons;
          stg_fail_d = matured & ~cons;
          for (int unsigned k = 1; k < DLY; k++) sr_d[k] = sr_q[k-1];
          sr_d[0] = ante;
        end
        default: ;
      endcase
    end
    if (clr) begin
      sr_d       = '{default: '0};
      stg_pass_d = '0;
      stg_fail_d = '0;
      stg_eval_d = 1'b0;
      pp_d       = '0;
      fp_d       = '0;
      pass_d     = '{default: '0};
      fail_d     = '{default: '0};
      cyc_d      = '0;
      ffv_d      = 1'b0;
      ffch_d     = '0;
      ffcyc_d    = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_OFF;
      sr_q       <= '{default: '0};
      stg_pass_q <= '0;
      stg_fail_q <= '0;
      stg_eval_q <= 1'b0;
      pp_q       <= '0;
      fp_q       <= '0;
      pass_q     <= '{default: '0};
      fail_q     <= '{default: '0};
      cyc_q      <= '0;
      ffv_q      <= 1'b0;
      ffch_q     <= '0;
      ffcyc_q    <= '0;
    end else begin
      mode_q     <= mode_d;
      sr_q       <= sr_d;
      stg_pass_q <= stg_pass_d;
      stg_fail_q <= stg_fail_d;
      stg_eval_q <= stg_eval_d;
      pp_q       <= pp_d;
      fp_q       <= fp_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      cyc_q      <= cyc_d;
      ffv_q      <= ffv_d;
      ffch_q     <= ffch_d;
      ffcyc_q    <= ffcyc_d;
    end
  end

`ifdef PCM_VACUOUS_CNT_EN
  logic [NCH-1:0]   stg_vac_q, stg_vac_d;
  logic [CNT_W-1:0] vac_q [NCH];
  logic [CNT_W-1:0] vac_d [NCH];

  // Vacuous-result staging and counting; matured-0 slots in IMPL only.
  always_comb begin
    stg_vac_d = '0;
    vac_d     = vac_q;
    for (int unsigned k = 0; k < NCH; k++)
      if (stg_vac_q[k]) vac_d[k] = sat_inc(vac_q[k]);
    if (eval && (mode_q == MODE_IMPL)) stg_vac_d = ~matured;
    if (clr) begin
      stg_vac_d = '0;
      vac_d     = '{default: '0};
    end
  end

  // Vacuous-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_vac_q <= '0;
      vac_q     <= '{default: '0};
    end else begin
      stg_vac_q <= stg_vac_d;
      vac_q     <= vac_d;
    end
  end

  // Pack the vacuous counters onto the output bus.
  always_comb begin
    vac_cnt = '0;
    for (int unsigned k = 0; k < NCH; k++) vac_cnt[k*CNT_W +: CNT_W] = vac_q[k];
  end
`else
  assign vac_cnt = '0;
`endif

  // Pack the per-channel counters onto the output buses.
  always_comb begin
    pass_cnt = '0;
    fail_cnt = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      pass_cnt[k*CNT_W +: CNT_W] = pass_q[k];
      fail_cnt[k*CNT_W +: CNT_W] = fail_q[k];
    end
  end

  assign pass_pulse     = pp_q;
  assign fail_pulse     = fp_q;
  assign cyc_cnt        = cyc_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_ch  = ffch_q;
  assign first_fail_cyc = ffcyc_q;

endmodule

// File: tb/tb_prop_chk_mon.sv
// Testbench for prop_chk_mon: a reference model built from queues and integer
// counters predicts the outputs after every edge. A monitor pops each
// prediction on the following negedge and compares it with the DUT.
module tb_prop_chk_mon;
  localparam int NCH   = 4;
  localparam int CNT_W = 4;
  localparam int DLY   = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1, clr = 1'b0, en = 1'b0;
  logic [1:0]           mode = 2'd3;
  logic [NCH-1:0]       ante = '0, cons = '0;
  logic [NCH-1:0]       pass_pulse, fail_pulse;
  logic [NCH*CNT_W-1:0] pass_cnt, fail_cnt, vac_cnt;
  logic [CNT_W-1:0]     cyc_cnt, first_fail_cyc;
  logic                 first_fail_vld;
  logic [4:0]           first_fail_ch;

  prop_chk_mon #(.NCH(NCH), .CNT_W(CNT_W), .DLY(DLY)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .mode(mode), .ante(ante), .cons(cons),
    .pass_pulse(pass_pulse), .fail_pulse(fail_pulse),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .vac_cnt(vac_cnt), .cyc_cnt(cyc_cnt),
    .first_fail_vld(first_fail_vld), .first_fail_ch(first_fail_ch),
    .first_fail_cyc(first_fail_cyc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0]       pp, fp;
    logic [NCH*CNT_W-1:0] pc, fc, vc;
    logic [CNT_W-1:0]     cyc, ffcyc;
    logic                 ffv;
    logic [4:0]           ffch;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int             m_pc[NCH], m_fc[NCH], m_vc[NCH];
  int             m_cyc, m_ffch, m_ffcyc;
  bit             m_ffv;
  bit [1:0]       m_mode;
  bit [NCH-1:0]   m_hist[$];
  bit [NCH-1:0]   pend_p, pend_f, pend_v, m_pp, m_fp;
  bit             pend_e;

  function automatic int sat(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin m_pc[i] = 0; m_fc[i] = 0; m_vc[i] = 0; end
    m_cyc = 0; m_ffv = 0; m_ffch = 0; m_ffcyc = 0;
    m_hist.delete();
    pend_p = '0; pend_f = '0; pend_v = '0; pend_e = 0; m_pp = '0; m_fp = '0;
  endtask

  // One edge of the specified behaviour; results from the previous edge land now.
  task automatic model_step(input bit r, input bit c, input bit e, input bit [1:0] md,
                            input bit [NCH-1:0] a, input bit [NCH-1:0] cn);
    bit [NCH-1:0] mat;
    if (r) begin
      model_clear(); m_mode = 2'd3;
    end else if (c) begin
      model_clear();
      if (e) m_mode = md;
    end else begin
      m_pp = pend_p; m_fp = pend_f;
      if (!m_ffv && pend_f != 0) begin
        m_ffv = 1; m_ffcyc = m_cyc;
        for (int i = NCH - 1; i >= 0; i--) if (pend_f[i]) m_ffch = i;
      end
      for (int i = 0; i < NCH; i++) begin
        if (pend_p[i]) m_pc[i] = sat(m_pc[i]);
        if (pend_f[i]) m_fc[i] = sat(m_fc[i]);
`ifdef PCM_VACUOUS_CNT_EN
        if (pend_v[i]) m_vc[i] = sat(m_vc[i]);
`endif
      end
      if (pend_e) m_cyc = sat(m_cyc);
      pend_p = '0; pend_f = '0; pend_v = '0; pend_e = 0;
      if (e) begin
        if (md != m_mode) begin
          m_mode = md; m_hist.delete();
        end else if (m_mode != 2'd3) begin
          pend_e = 1;
          case (m_mode)
            2'd0: begin pend_p = cn; pend_f = ~cn; end
            2'd1: begin pend_p = ~cn; pend_f = cn; end
            default: begin
              m_hist.push_back(a);
              mat = (m_hist.size() > DLY) ? m_hist.pop_front() : '0;
              pend_p = mat & cn; pend_f = mat & ~cn; pend_v = ~mat;
            end
          endcase
        end
      end
    end
  endtask

  task automatic push_exp();
    exp_t x;
    x.pp = m_pp; x.fp = m_fp;
    for (int i = 0; i < NCH; i++) begin
      x.pc[i*CNT_W +: CNT_W] = m_pc[i][CNT_W-1:0];
      x.fc[i*CNT_W +: CNT_W] = m_fc[i][CNT_W-1:0];
      x.vc[i*CNT_W +: CNT_W] = m_vc[i][CNT_W-1:0];
    end
    x.cyc = m_cyc[CNT_W-1:0]; x.ffv = m_ffv; x.ffch = m_ffch[4:0];
    x.ffcyc = m_ffcyc[CNT_W-1:0];
    sbq.push_back(x);
  endtask

  task automatic step(input bit r, input bit c, input bit e, input bit [1:0] md,
                      input bit [NCH-1:0] a, input bit [NCH-1:0] cn);
    rst = r; clr = c; en = e; mode = md; ante = a; cons = cn;
    @(posedge clk);
    model_step(r, c, e, md, a, cn);
    push_exp();
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      exp_t x;
      x = sbq.pop_front();
      chk("pass_pulse", 64'(pass_pulse), 64'(x.pp));
      chk("fail_pulse", 64'(fail_pulse), 64'(x.fp));
      chk("pass_cnt", 64'(pass_cnt), 64'(x.pc));
      chk("fail_cnt", 64'(fail_cnt), 64'(x.fc));
      chk("vac_cnt", 64'(vac_cnt), 64'(x.vc));
      chk("cyc_cnt", 64'(cyc_cnt), 64'(x.cyc));
      chk("first_fail_vld", 64'(first_fail_vld), 64'(x.ffv));
      chk("first_fail_ch", 64'(first_fail_ch), 64'(x.ffch));
      chk("first_fail_cyc", 64'(first_fail_cyc), 64'(x.ffcyc));
    end
  end

  initial begin
    bit [1:0] md;
    m_mode = 2'd3;
    model_clear();
    step(1, 0, 0, 2'd3, '0, '0);
    step(1, 0, 0, 2'd3, '0, '0);
    chk("reset_pass_cnt", 64'(pass_cnt), 64'd0);

    // HIGH, ten passing evaluations
    step(0, 0, 1, 2'd0, '0, 4'hF);
    repeat (10) step(0, 0, 1, 2'd0, '0, 4'hF);
    step(0, 0, 0, 2'd0, '0, '0);
    chk("high10_pass_cnt", 64'(pass_cnt), 64'({4{4'd10}}));
    chk("high10_ffv", 64'(first_fail_vld), 64'd0);

    // HIGH, channel 2 fails on the fourth evaluation
    step(0, 1, 1, 2'd0, '0, 4'hF);
    repeat (3) step(0, 0, 1, 2'd0, '0, 4'hF);
    step(0, 0, 1, 2'd0, '0, 4'b1011);
    step(0, 0, 0, 2'd0, '0, '0);
    chk("ch2_fail_pulse", 64'(fail_pulse), 64'h4);
    chk("ch2_ffch", 64'(first_fail_ch), 64'd2);
    chk("ch2_ffcyc", 64'(first_fail_cyc), 64'd3);

    // IMPL: attempt on ch0 matures two evaluations later
    step(0, 1, 1, 2'd0, '0, '0);
    step(0, 0, 1, 2'd2, '0, '0);
    repeat (3) step(0, 0, 1, 2'd2, '0, '0);
    step(0, 0, 1, 2'd2, 4'h1, '0);
    step(0, 0, 1, 2'd2, '0, '0);
    step(0, 0, 1, 2'd2, '0, 4'hF);
    step(0, 0, 0, 2'd2, '0, '0);
    chk("impl_pass_pulse", 64'(pass_pulse), 64'h1);
    step(0, 0, 1, 2'd2, 4'h1, '0);
    step(0, 0, 1, 2'd2, '0, '0);
    step(0, 0, 1, 2'd2, '0, 4'hE);
    step(0, 0, 0, 2'd2, '0, '0);
    chk("impl_fail_pulse", 64'(fail_pulse), 64'h1);

    // Saturation after 20 passing HIGH evaluations
    step(0, 1, 1, 2'd0, '0, '0);
    repeat (20) step(0, 0, 1, 2'd0, '0, 4'hF);
    step(0, 0, 0, 2'd0, '0, '0);
    chk("sat_pass_cnt", 64'(pass_cnt), 64'({4{4'd15}}));

    // Simultaneous ch1/ch3 failures, then ch0
    step(0, 1, 1, 2'd0, '0, '0);
    step(0, 0, 1, 2'd0, '0, 4'b0101);
    step(0, 0, 1, 2'd0, '0, 4'b1110);
    step(0, 0, 0, 2'd0, '0, '0);
    chk("multi_ffch", 64'(first_fail_ch), 64'd1);
    chk("multi_ffcyc", 64'(first_fail_cyc), 64'd0);
    step(0, 1, 0, 2'd0, '0, '0);
    chk("clr_ffv", 64'(first_fail_vld), 64'd0);
    chk("clr_fail_cnt", 64'(fail_cnt), 64'd0);

    // IMPL with pending attempts, switch to LOW, then hold with en=0
    step(0, 0, 1, 2'd2, '0, '0);
    step(0, 0, 1, 2'd2, 4'hF, '0);
    step(0, 0, 1, 2'd1, '0, '0);
    repeat (2) step(0, 0, 1, 2'd1, '0, 4'h3);
    repeat (5) step(0, 0, 0, 2'd1, $urandom, $urandom);

    // Randomized traffic
    md = 2'd0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) md = 2'($urandom_range(0, 3));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 99) < 85, md, NCH'($urandom), NCH'($urandom));
    end
    step(0, 0, 0, md, '0, '0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
